// File: rtl/perf_counter_snapshot_reader_if.sv
// Read-stream interface of the performance counter snapshot reader:
// one captured counter per beat, with valid/ready flow control.
interface perf_counter_snapshot_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) ();

    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ID_WIDTH-1:0]   rd_id;
    logic                  rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_id,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_id,
        input  rd_last,
        output rd_ready
    );

endinterface

// File: rtl/perf_counter_snapshot_reader.sv
// Captures the whole counter bank atomically on snap_req, optionally clears it,
// then streams the shadow copy out one counter per beat.
module perf_counter_snapshot_reader #(
    parameter int NUM_COUNTERS  = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 2,
    parameter int CLEAR_ON_SNAP = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_COUNTERS*DATA_WIDTH-1:0] counter_bus,
    input  logic                               snap_req,
    perf_counter_snapshot_reader_if.master     rd,
    output logic                               busy,
    output logic                               counters_clr,
    output logic                               snap_overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_COUNTERS - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shadow [NUM_COUNTERS];
    logic                  xfer;
    logic                  accept;
    logic [ID_WIDTH-1:0]   next_id;

    // NOTE: every always_comb output is assigned unconditionally so no latch can be inferred.
    always_comb begin
        xfer    = rd.rd_valid & rd.rd_ready;
        // The last beat frees the shadow bank, so a request on that edge starts a fresh capture.
        accept  = snap_req & ((state == IDLE) | (xfer & rd.rd_last));
        next_id = rd.rd_id + 1'b1;
    end

    // busy is a straight copy of the registered rd_valid, so it stays glitch-free.
    assign busy = rd.rd_valid;

    // NOTE: all state here is sequential and uses non-blocking assignments so every
    // register samples pre-edge values, which keeps the capture truly atomic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd.rd_valid  <= 1'b0;
            rd.rd_id     <= '0;
            rd.rd_data   <= '0;
            rd.rd_last   <= 1'b0;
            counters_clr <= 1'b0;
            snap_overrun <= 1'b0;
            // NOTE: the shadow bank is small and must read as zero after reset, so it is
            // reset like any other register rather than left as an unreset memory.
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            counters_clr <= 1'b0;
            if (accept) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    shadow[i] <= counter_bus[i*DATA_WIDTH +: DATA_WIDTH];
                end
                state        <= STREAM;
                rd.rd_valid  <= 1'b1;
                rd.rd_id     <= '0;
                rd.rd_data   <= counter_bus[DATA_WIDTH-1:0];
                rd.rd_last   <= (NUM_COUNTERS == 1);
                counters_clr <= (CLEAR_ON_SNAP != 0);
                snap_overrun <= 1'b0;
            end else if (state == STREAM) begin
                if (snap_req) begin
                    snap_overrun <= 1'b1;
                end
                if (xfer) begin
                    if (rd.rd_last) begin
                        state       <= IDLE;
                        rd.rd_valid <= 1'b0;
                        rd.rd_id    <= '0;
                        rd.rd_data  <= '0;
                        rd.rd_last  <= 1'b0;
                    end else begin
                        rd.rd_id    <= next_id;
                        rd.rd_data  <= shadow[next_id];
                        rd.rd_last  <= (next_id == LAST_ID);
                    end
                end
            end
        end
    end

endmodule
